load_writeback: RTL
===================

# load_writeback

Write-back stage of the multi-cycle MIPS CPU: the sole driver of the register file's write port (`RegWrite`, `writeR`, `writedata`). For loads it issues the data-memory read and holds it through `mem_waitrequest`. It then extracts and sign- or zero-extends the addressed byte or halfword, or merges it with the old `rt` value for LWL/LWR. It resolves link destinations (JAL, BGEZAL, BLTZAL, JALR with rd=0 go to `$31`) so the register file only ever sees a final index and value.

## Interface
Parameters:
- `LINK_REG`, 31, destination index for link writes.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: one-cycle request from the control FSM at WRITE_BACK entry; ignored unless idle.
- `instr` in 32: current instruction, sampled on accepted `start`.
- `eff_addr` in 32: load effective address, sampled on `start`.
- `alu_result` in 32: result for non-load, non-link writes.
- `link_pc` in 32: return address for link writes.
- `rt_old` in 32: current `rt` contents, sampled on `start`; used only for LWL/LWR.
- `mem_readdata` in 32: memory read data, valid in the cycle `mem_waitrequest`=0 while `mem_read`=1.
- `mem_waitrequest` in 1: memory stall.
- `mem_read` out 1: memory read request.
- `mem_address` out 32: `{eff_addr[31:2],2'b00}`.
- `mem_byteenable` out 4: fixed at `4'b1111`.
- `RegWrite` out 1: register-file write strobe.
- `writeR` out 5: destination index.
- `writedata` out 32: destination value.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `addr_error` out 1: one-cycle pulse when an access is misaligned.

## Operation
- FSM states: IDLE, REQ, WRITE.
  - IDLE + `start`, load opcode, aligned -> REQ.
  - IDLE + `start`, load opcode, misaligned -> IDLE, with `addr_error`=1 and `done`=1 for one cycle, and no write.
  - IDLE + `start`, any other opcode -> WRITE.
  - REQ -> WRITE on the first edge with `mem_waitrequest`=0; `mem_readdata` is captured on that edge.
  - WRITE -> IDLE unconditionally.
- Load opcodes: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110.
- Misalignment rules: LH/LHU with `eff_addr[0]`=1; LW with `eff_addr[1:0]`≠0.
- Lane order is little-endian: byte k = `mem_readdata[8k+7:8k]`, with k = `eff_addr[1:0]`.
- Extraction:
  - LB/LBU: byte k, sign- or zero-extended.
  - LH/LHU: halfword at lane k (k = 0 or 2), sign- or zero-extended.
  - LW: whole word.
- LWL with offset k: `(mem << 8*(3-k)) | (rt_old & low (3-k) bytes mask)`. k=3 gives the full word.
- LWR with offset k: `(mem >> 8k) | (rt_old & high k bytes mask)`. k=0 gives the full word.
- Destination selection:
  - JAL (000011), or REGIMM (000001) with rt=10000/10001: `LINK_REG`, data = `link_pc`.
  - SPECIAL JALR (funct 001001): rd, or `LINK_REG` if rd=0; data = `link_pc`.
  - Other SPECIAL: rd, data = `alu_result`.
  - Loads and other I-type: rt; loads use the extracted value, others use `alu_result`.
- Any resolved destination of 0 suppresses `RegWrite`. `done` still pulses.
- `start` while `busy` is ignored; no queuing.

## Timing
- `RegWrite`, `writeR`, `writedata` and `done` are registered and asserted only in the WRITE state, for exactly one cycle. The register file commits on the next rising edge.
- Non-load latency: `start` at cycle N, then WRITE at N+1.
- Load latency: `start` at N, then REQ from N+1. With zero wait states, WRITE is at N+2; each wait cycle adds 1.
- `mem_read` is high in every REQ cycle. `mem_address` is stable from REQ entry until `mem_waitrequest`=0.
- Reset values: all outputs 0 except `mem_byteenable`=4'b1111; state IDLE.
- Reset asserted mid-REQ: `mem_read` drops on that edge, no write is issued, and a late `mem_readdata` is ignored.

## Configuration
- `WB_UNALIGNED_EN` defined: LWL/LWR are supported as described, with no alignment check.
- Not defined: LWL/LWR are treated as reserved. There is no memory access and no write; `addr_error`=1 and `done`=1 for one cycle. The merge logic is removed.

## Test plan
- LB, `eff_addr`=0x1003, `mem_readdata`=0x80112233, rt=5, 0 wait states -> at cycle N+2: `RegWrite`=1, `writeR`=5, `writedata`=0xFFFFFF80. For LBU, `writedata`=0x00000080.
- LHU, `eff_addr`=0x2002, `mem_waitrequest` high for 3 cycles, data 0xBEEF1234 -> `mem_read` high for 4 cycles, `mem_address`=0x2000, `writedata`=0x0000BEEF at N+5.
- LWL, `eff_addr`=0x...1, `rt_old`=0xAABBCCDD, mem 0x11223344 -> `writedata`=0x3344CCDD. LWR at offset 2 with the same inputs -> 0xAABB1122. Without `WB_UNALIGNED_EN`: `addr_error` pulses and there is no write.
- JALR, rd=0, `link_pc`=0xBFC00008 -> `writeR`=31, `writedata`=0xBFC00008. ADDU with rd=0 -> `RegWrite`=0 and `done`=1.
- LW with `eff_addr`=0x1002 -> `addr_error`=1 and `done`=1 at N+1, `mem_read` never asserted.
- `reset`=0 asserted during a REQ stall -> next cycle `mem_read`=0 and `busy`=0, no `RegWrite`. A second `start` while busy is ignored.

Source files
------------

// File: rtl/load_writeback.sv
// Write-back stage of the multi-cycle MIPS CPU: issues load reads, extracts/merges load data and
// resolves link destinations. Define WB_UNALIGNED_EN to support LWL/LWR (else they are reserved).
module load_writeback #(
  parameter int unsigned LINK_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] eff_addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] link_pc,
  input  logic [31:0] rt_old,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        RegWrite,
  output logic [4:0]  writeR,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        done,
  output logic        addr_error
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpLb      = 6'b100000;
  localparam logic [5:0] OpLh      = 6'b100001;
  localparam logic [5:0] OpLwl     = 6'b100010;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpLbu     = 6'b100100;
  localparam logic [5:0] OpLhu     = 6'b100101;
  localparam logic [5:0] OpLwr     = 6'b100110;
  localparam logic [5:0] FnJalr    = 6'b001001;
  localparam logic [4:0] LinkIdx   = 5'(LINK_REG);

  typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  ofs_q, ofs_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] addr_q, addr_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_r_q, write_r_d;
  logic [31:0] write_data_q, write_data_d;
  logic        done_q, done_d;
  logic        addr_error_q, addr_error_d;

  logic [5:0] opcode, funct;
  logic [4:0] rt, rd;
  assign opcode = instr[31:26];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  logic unused_instr;
  assign unused_instr = ^{instr[25:21], instr[10:6]};

  logic is_load, is_unaligned_op, misaligned, reserved;
  assign is_load         = (opcode[5:3] == 3'b100) && (opcode[2:0] != 3'b111);
  assign is_unaligned_op = (opcode == OpLwl) || (opcode == OpLwr);

  always_comb begin
    misaligned = 1'b0;
    case (opcode)
      OpLh, OpLhu: misaligned = eff_addr[0];
      OpLw:        misaligned = |eff_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

`ifdef WB_UNALIGNED_EN
  assign reserved = 1'b0;

  logic [31:0] rt_old_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      rt_old_q <= '0;
    end else if (state_q == StIdle && start && is_load) begin
      rt_old_q <= rt_old;
    end
  end
`else
  assign reserved = is_unaligned_op;

  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  // Non-load destination: links always land in LinkIdx except JALR with a nonzero rd.
  logic [4:0]  nl_dst;
  logic [31:0] nl_data;
  always_comb begin
    nl_dst  = rt;
    nl_data = alu_result;
    if (opcode == OpJal || (opcode == OpRegimm && rt[4:1] == 4'b1000)) begin
      nl_dst  = LinkIdx;
      nl_data = link_pc;
    end else if (opcode == OpSpecial) begin
      nl_dst = rd;
      if (funct == FnJalr) begin
        nl_data = link_pc;
        if (rd == 5'd0) nl_dst = LinkIdx;
      end
    end
  end

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    lane_byte = mem_readdata[7:0];
    case (ofs_q)
      2'd0: lane_byte = mem_readdata[7:0];
      2'd1: lane_byte = mem_readdata[15:8];
      2'd2: lane_byte = mem_readdata[23:16];
      2'd3: lane_byte = mem_readdata[31:24];
      default: lane_byte = mem_readdata[7:0];
    endcase
  end

  assign lane_half = ofs_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];

  always_comb begin
    load_data = mem_readdata;
    case (op_q)
      OpLb:  load_data = {{24{lane_byte[7]}}, lane_byte};
      OpLbu: load_data = {24'h0, lane_byte};
      OpLh:  load_data = {{16{lane_half[15]}}, lane_half};
      OpLhu: load_data = {16'h0, lane_half};
`ifdef WB_UNALIGNED_EN
      // LWL fills from the top, keeping the low (3-k) bytes of rt; LWR is the mirror image.
      OpLwl: load_data = (mem_readdata << {~ofs_q, 3'b000}) |
                         (rt_old_q & (32'h00FF_FFFF >> {ofs_q, 3'b000}));
      OpLwr: load_data = (mem_readdata >> {ofs_q, 3'b000}) |
                         (rt_old_q & ~(32'hFFFF_FFFF >> {ofs_q, 3'b000}));
`endif
      default: load_data = mem_readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ofs_d        = ofs_q;
    dst_d        = dst_q;
    addr_d       = addr_q;
    reg_write_d  = 1'b0;
    write_r_d    = '0;
    write_data_d = '0;
    done_d       = 1'b0;
    addr_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_load) begin
            if (reserved || misaligned) begin
              addr_error_d = 1'b1;
              done_d       = 1'b1;
            end else begin
              state_d = StReq;
              op_d    = opcode;
              ofs_d   = eff_addr[1:0];
              dst_d   = rt;
              addr_d  = {eff_addr[31:2], 2'b00};
            end
          end else begin
            state_d      = StWrite;
            reg_write_d  = (nl_dst != 5'd0);
            write_r_d    = nl_dst;
            write_data_d = nl_data;
            done_d       = 1'b1;
          end
        end
      end
      StReq: begin
        if (!mem_waitrequest) begin
          state_d      = StWrite;
          reg_write_d  = (dst_q != 5'd0);
          write_r_d    = dst_q;
          write_data_d = load_data;
          done_d       = 1'b1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      ofs_q        <= '0;
      dst_q        <= '0;
      addr_q       <= '0;
      reg_write_q  <= 1'b0;
      write_r_q    <= '0;
      write_data_q <= '0;
      done_q       <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ofs_q        <= ofs_d;
      dst_q        <= dst_d;
      addr_q       <= addr_d;
      reg_write_q  <= reg_write_d;
      write_r_q    <= write_r_d;
      write_data_q <= write_data_d;
      done_q       <= done_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign mem_read       = (state_q == StReq);
  assign mem_address    = addr_q;
  assign mem_byteenable = 4'b1111;
  assign RegWrite       = reg_write_q;
  assign writeR         = write_r_q;
  assign writedata      = write_data_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign addr_error     = addr_error_q;

endmodule
